// File: rtl/accumulator_alu.sv
// accumulator_alu: WIDTH-bit W-bus accumulator with an integrated ALU.
// Single-cycle add/sub/inc/dec with registered C/Z/N/V flags, plus
// multi-cycle serial shifts and rotates accepted under a valid/ready handshake.
module accumulator_alu #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic [WIDTH-1:0]   bus_input,
    input  logic               L_A_bar,
    input  logic               E_A,
    input  logic [2:0]         op,
    input  logic               op_valid,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               op_ready,
    output logic               busy,
    output logic [WIDTH-1:0]   bus_output,
    output logic [WIDTH-1:0]   add_sub_output,
    output logic               flag_C,
    output logic               flag_Z,
    output logic               flag_N,
    output logic               flag_V
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_INC = 3'b011;
    localparam logic [2:0] OP_DEC = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [WIDTH-1:0]     r_acc;
    logic [SHAMT_W-1:0]   r_count;
    logic [2:0]           r_shOp;
    logic                 r_flagC;
    logic                 r_flagZ;
    logic                 r_flagN;
    logic                 r_flagV;

    logic                 w_accept;
    logic                 w_isArith;
    logic                 w_isShift;
    logic                 w_startShift;
    logic [WIDTH-1:0]     w_opB;
    logic                 w_cin;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_result;
    logic                 w_overflow;
    logic [WIDTH-1:0]     w_shiftVal;
    logic                 w_shiftC;

    assign w_accept     = op_ready && op_valid;
    assign w_isArith    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC) || (op == OP_DEC);
    assign w_isShift    = (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROR);
    assign w_startShift = w_accept && w_isShift && (shamt != '0);

    // State register: the only FSM flop, cleared straight to IDLE by CLR even mid-shift.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: enter SHIFT on a non-zero shift request, leave when the last step is taken.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_startShift) begin
                    w_nextState = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_count == SHAMT_W'(1)) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // FSM outputs: ready only in IDLE with no bus load pending, busy throughout SHIFT.
    always_comb begin
        op_ready = (r_state == ST_IDLE) && L_A_bar;
        busy     = (r_state == ST_SHIFT);
    end

    // Adder operand select: every arithmetic op is A + B' + cin on one (WIDTH+1)-bit adder.
    always_comb begin
        w_opB = '0;
        w_cin = 1'b0;
        case (op)
            OP_ADD: w_opB = bus_input;
            OP_SUB: begin
                w_opB = ~bus_input;
                w_cin = 1'b1;
            end
            OP_INC: w_cin = 1'b1;
            OP_DEC: w_opB = '1;
            default: w_opB = '0;
        endcase
    end

    assign w_sum      = {1'b0, r_acc} + {1'b0, w_opB} + {{WIDTH{1'b0}}, w_cin};
    assign w_result   = w_sum[WIDTH-1:0];
    assign w_overflow = (r_acc[WIDTH-1] == w_opB[WIDTH-1]) && (w_result[WIDTH-1] != r_acc[WIDTH-1]);

    // One serial shift step of the latched shift op, with the bit that falls out going to carry.
    always_comb begin
        w_shiftVal = r_acc;
        w_shiftC   = 1'b0;
        case (r_shOp)
            OP_SHL: begin
                w_shiftVal = {r_acc[WIDTH-2:0], 1'b0};
                w_shiftC   = r_acc[WIDTH-1];
            end
            OP_SHR: begin
                w_shiftVal = {1'b0, r_acc[WIDTH-1:1]};
                w_shiftC   = r_acc[0];
            end
            default: begin
                w_shiftVal = {r_acc[0], r_acc[WIDTH-1:1]};
                w_shiftC   = r_acc[0];
            end
        endcase
    end

    // Datapath: load has priority over ops in IDLE; SHIFT ignores load and new requests.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_acc   <= '0;
            r_count <= '0;
            r_shOp  <= OP_NOP;
            r_flagC <= 1'b0;
            r_flagZ <= 1'b1;
            r_flagN <= 1'b0;
            r_flagV <= 1'b0;
        end else if (r_state == ST_SHIFT) begin
            r_acc   <= w_shiftVal;
            r_count <= r_count - SHAMT_W'(1);
            r_flagC <= w_shiftC;
            r_flagZ <= (w_shiftVal == '0);
            r_flagN <= w_shiftVal[WIDTH-1];
            r_flagV <= 1'b0;
        end else if (!L_A_bar) begin
            r_acc   <= bus_input;
            r_flagZ <= (bus_input == '0);
            r_flagN <= bus_input[WIDTH-1];
        end else if (op_valid) begin
            if (w_isArith) begin
                r_acc   <= w_result;
                r_flagC <= w_sum[WIDTH];
                r_flagZ <= (w_result == '0);
                r_flagN <= w_result[WIDTH-1];
                r_flagV <= w_overflow;
            end else if (w_startShift) begin
                r_shOp  <= op;
                r_count <= shamt;
            end
        end
    end

    assign add_sub_output = r_acc;
    assign bus_output     = E_A ? r_acc : {WIDTH{1'bz}};
    assign flag_C         = r_flagC;
    assign flag_Z         = r_flagZ;
    assign flag_N         = r_flagN;
    assign flag_V         = r_flagV;

endmodule
